// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side, memory-side and status signals for the shared memory port.
// The arbiter takes the slave view; the requesters and the memory take the master view.
interface mem_port_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_valid;
   logic [DW-1:0] if_rdata;

   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt;
   logic          dm_valid;
   logic [DW-1:0] dm_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          busy;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch (IF) and data access (DM).
// Each access holds the memory for MEM_LAT cycles, then pulses the owner's valid for one cycle.
module mem_port_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 8,
   parameter int MEM_LAT      = 1,
   parameter int DM_BURST_MAX = 3
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   localparam int CW = $clog2(MEM_LAT + 1);
   localparam int BW = $clog2(DM_BURST_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [BW-1:0] consec_dm_reg, consec_dm_next;
   logic          owner_dm_reg, owner_dm_next;
   logic          we_reg, we_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic [DW-1:0] wdata_reg, wdata_next;
   logic [DW-1:0] if_rdata_reg, if_rdata_next;
   logic [DW-1:0] dm_rdata_reg, dm_rdata_next;

   logic          any_req;
   logic          grant_dm;

   // DM normally wins; IF gets the port once DM has taken DM_BURST_MAX grants in a row on it.
   assign any_req  = bus.if_req | bus.dm_req;
   assign grant_dm = bus.dm_req & ~(bus.if_req & (consec_dm_reg == BW'(DM_BURST_MAX)));

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      consec_dm_next = consec_dm_reg;
      owner_dm_next  = owner_dm_reg;
      we_next        = we_reg;
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      if_rdata_next  = if_rdata_reg;
      dm_rdata_next  = dm_rdata_reg;

      case (state_reg)
         ST_IDLE, ST_DONE: begin
            state_next = ST_IDLE;
            if (!bus.if_req) begin
               consec_dm_next = '0;
            end else if (grant_dm) begin
               if (consec_dm_reg != BW'(DM_BURST_MAX)) begin
                  consec_dm_next = consec_dm_reg + BW'(1);
               end
            end else begin
               consec_dm_next = '0;
            end

            if (any_req) begin
               state_next    = ST_ACCESS;
               cnt_next      = CW'(MEM_LAT);
               owner_dm_next = grant_dm;
               we_next       = grant_dm & bus.dm_we;
               addr_next     = grant_dm ? bus.dm_addr : bus.if_addr;
               wdata_next    = grant_dm ? bus.dm_wdata : '0;
            end
         end

         ST_ACCESS: begin
            cnt_next = cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
               state_next = ST_DONE;
               // Stores leave the load data register untouched.
               if (!we_reg) begin
                  if (owner_dm_reg) begin
                     dm_rdata_next = bus.mem_rdata;
                  end else begin
                     if_rdata_next = bus.mem_rdata;
                  end
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         consec_dm_reg <= '0;
         owner_dm_reg  <= 1'b0;
         we_reg        <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         if_rdata_reg  <= '0;
         dm_rdata_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         consec_dm_reg <= consec_dm_next;
         owner_dm_reg  <= owner_dm_next;
         we_reg        <= we_next;
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         if_rdata_reg  <= if_rdata_next;
         dm_rdata_reg  <= dm_rdata_next;
      end
   end

   // Every output is a register or a decode of registered state.
   assign bus.mem_en    = (state_reg == ST_ACCESS);
   assign bus.mem_we    = (state_reg == ST_ACCESS) & owner_dm_reg & we_reg;
   assign bus.mem_addr  = addr_reg;
   assign bus.mem_wdata = wdata_reg;
   assign bus.if_gnt    = (state_reg == ST_ACCESS) & ~owner_dm_reg;
   assign bus.dm_gnt    = (state_reg == ST_ACCESS) & owner_dm_reg;
   assign bus.if_valid  = (state_reg == ST_DONE) & ~owner_dm_reg;
   assign bus.dm_valid  = (state_reg == ST_DONE) & owner_dm_reg;
   assign bus.if_rdata  = if_rdata_reg;
   assign bus.dm_rdata  = dm_rdata_reg;
   assign bus.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 (bus1) and one with MEM_LAT=3 (bus3), each with a memory
// model that returns 8'hEE unless mem_en has been held exactly up to the last access cycle.
module tb_mem_port_arbiter;

   logic clk;
   logic rst;
   logic preload;
   int   total;
   int   bad;

   mem_port_arbiter_if #(.AW(8), .DW(8)) bus1 ();
   mem_port_arbiter_if #(.AW(8), .DW(8)) bus3 ();

   mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(1), .DM_BURST_MAX(3)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(3), .DM_BURST_MAX(3)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: preload mem[a] = a ^ 8'hB5, write on every mem_we cycle.
   logic [7:0] mem1 [256];
   logic [7:0] mem3 [256];
   int         hold1;
   int         hold3;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) begin
            mem1[i] <= 8'(i) ^ 8'hB5;
            mem3[i] <= 8'(i) ^ 8'hB5;
         end
      end else begin
         if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
         if (bus3.mem_en && bus3.mem_we) mem3[bus3.mem_addr] <= bus3.mem_wdata;
      end
      hold1 <= bus1.mem_en ? hold1 + 1 : 0;
      hold3 <= bus3.mem_en ? hold3 + 1 : 0;
   end

   assign bus1.mem_rdata = (bus1.mem_en && hold1 == 0) ? mem1[bus1.mem_addr] : 8'hEE;
   assign bus3.mem_rdata = (bus3.mem_en && hold3 == 2) ? mem3[bus3.mem_addr] : 8'hEE;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one complete access on the MEM_LAT=3 arbiter; lat=0 means no valid within the bound.
   task automatic op3(input bit use_dm, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                      output int lat, output int gnt_cyc, output int we_cyc, output logic [7:0] rdata);
      lat = 0;
      gnt_cyc = 0;
      we_cyc = 0;
      rdata = 8'h00;
      if (use_dm) begin
         bus3.dm_req = 1'b1;
         bus3.dm_we = we;
         bus3.dm_addr = addr;
         bus3.dm_wdata = wdata;
      end else begin
         bus3.if_req = 1'b1;
         bus3.if_addr = addr;
      end
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (use_dm ? bus3.dm_gnt : bus3.if_gnt) gnt_cyc++;
         if (bus3.mem_we) we_cyc++;
         if (use_dm ? bus3.dm_valid : bus3.if_valid) begin
            lat = i;
            rdata = use_dm ? bus3.dm_rdata : bus3.if_rdata;
            break;
         end
      end
      bus3.dm_req = 1'b0;
      bus3.dm_we = 1'b0;
      bus3.if_req = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [38:0] outs1;
      logic [38:0] outs3;
      rst = 1'b1;
      preload = 1'b1;
      tick();
      tick();
      tick();
      preload = 1'b0;
      outs1 = {bus1.if_gnt, bus1.if_valid, bus1.if_rdata, bus1.dm_gnt, bus1.dm_valid, bus1.dm_rdata,
               bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.busy};
      outs3 = {bus3.if_gnt, bus3.if_valid, bus3.if_rdata, bus3.dm_gnt, bus3.dm_valid, bus3.dm_rdata,
               bus3.mem_en, bus3.mem_we, bus3.mem_addr, bus3.mem_wdata, bus3.busy};
      total++;
      if (outs1 !== 39'h0) begin bad++; $display("FAIL reset_outs_lat1: got %h want 0", outs1); end
      total++;
      if (outs3 !== 39'h0) begin bad++; $display("FAIL reset_outs_lat3: got %h want 0", outs3); end
      rst = 1'b0;
      tick();
      $display("test_reset: outputs checked after reset");
   endtask

   task automatic test_fetch_lat1();
      bus1.if_req = 1'b1;
      bus1.if_addr = 8'h10;
      tick();
      total++;
      if ({bus1.if_gnt, bus1.mem_en, bus1.mem_we, bus1.if_valid, bus1.busy} !== 5'b11001) begin
         bad++;
         $display("FAIL fetch_cycle1_ctrl: got %b want 11001",
                  {bus1.if_gnt, bus1.mem_en, bus1.mem_we, bus1.if_valid, bus1.busy});
      end
      total++;
      if (bus1.mem_addr !== 8'h10) begin bad++; $display("FAIL fetch_addr: got %h want 10", bus1.mem_addr); end
      tick();
      total++;
      if ({bus1.if_valid, bus1.if_gnt, bus1.mem_en} !== 3'b100) begin
         bad++;
         $display("FAIL fetch_cycle2_ctrl: got %b want 100", {bus1.if_valid, bus1.if_gnt, bus1.mem_en});
      end
      total++;
      if (bus1.if_rdata !== 8'hA5) begin bad++; $display("FAIL fetch_rdata: got %h want a5", bus1.if_rdata); end
      bus1.if_req = 1'b0;
      tick();
      total++;
      if ({bus1.busy, bus1.if_valid} !== 2'b00) begin
         bad++;
         $display("FAIL fetch_idle: got %b want 00", {bus1.busy, bus1.if_valid});
      end
      $display("test_fetch_lat1: fetch 0x10 -> %h", bus1.if_rdata);
   endtask

   task automatic test_store_load();
      int lat;
      int gnt_cyc;
      int we_cyc;
      logic [7:0] rdata;
      op3(1'b1, 1'b0, 8'h30, 8'h00, lat, gnt_cyc, we_cyc, rdata);
      total++;
      if (lat !== 4) begin bad++; $display("FAIL load30_latency: got %0d want 4", lat); end
      total++;
      if (rdata !== 8'h85) begin bad++; $display("FAIL load30_rdata: got %h want 85", rdata); end
      $display("test_store_load: load 0x30 lat=%0d data=%h", lat, rdata);

      op3(1'b1, 1'b1, 8'h20, 8'h3C, lat, gnt_cyc, we_cyc, rdata);
      total++;
      if (lat !== 4) begin bad++; $display("FAIL store_latency: got %0d want 4", lat); end
      total++;
      if (we_cyc !== 3) begin bad++; $display("FAIL store_mem_we_cycles: got %0d want 3", we_cyc); end
      total++;
      if (gnt_cyc !== 3) begin bad++; $display("FAIL store_gnt_cycles: got %0d want 3", gnt_cyc); end
      total++;
      if (bus3.dm_rdata !== 8'h85) begin bad++; $display("FAIL store_keeps_rdata: got %h want 85", bus3.dm_rdata); end
      total++;
      if (mem3[8'h20] !== 8'h3C) begin bad++; $display("FAIL store_landed: got %h want 3c", mem3[8'h20]); end
      $display("test_store_load: store 0x20<=3c lat=%0d we_cycles=%0d", lat, we_cyc);

      op3(1'b1, 1'b0, 8'h20, 8'h00, lat, gnt_cyc, we_cyc, rdata);
      total++;
      if (rdata !== 8'h3C) begin bad++; $display("FAIL load20_rdata: got %h want 3c", rdata); end
      total++;
      if (we_cyc !== 0) begin bad++; $display("FAIL load20_no_write: got %0d want 0", we_cyc); end
      $display("test_store_load: load 0x20 lat=%0d data=%h", lat, rdata);
   endtask

   task automatic test_back_to_back();
      bus1.if_req = 1'b1;
      bus1.if_addr = 8'h11;
      bus1.dm_req = 1'b1;
      bus1.dm_we = 1'b0;
      bus1.dm_addr = 8'h12;
      tick();
      total++;
      if ({bus1.dm_gnt, bus1.if_gnt} !== 2'b10) begin
         bad++;
         $display("FAIL b2b_dm_first: got %b want 10", {bus1.dm_gnt, bus1.if_gnt});
      end
      tick();
      total++;
      if ({bus1.dm_valid, bus1.dm_rdata} !== {1'b1, 8'hA7}) begin
         bad++;
         $display("FAIL b2b_dm_done: got %b/%h want 1/a7", bus1.dm_valid, bus1.dm_rdata);
      end
      bus1.dm_req = 1'b0;
      tick();
      total++;
      if ({bus1.if_gnt, bus1.busy, bus1.mem_addr} !== {2'b11, 8'h11}) begin
         bad++;
         $display("FAIL b2b_if_next: got gnt=%b busy=%b addr=%h want 1/1/11",
                  bus1.if_gnt, bus1.busy, bus1.mem_addr);
      end
      tick();
      total++;
      if ({bus1.if_valid, bus1.if_rdata} !== {1'b1, 8'hA4}) begin
         bad++;
         $display("FAIL b2b_if_done: got %b/%h want 1/a4", bus1.if_valid, bus1.if_rdata);
      end
      bus1.if_req = 1'b0;
      tick();
      $display("test_back_to_back: dm=%h then if=%h", bus1.dm_rdata, bus1.if_rdata);
   endtask

   task automatic test_burst_fairness();
      logic [7:0] order [8];
      logic [7:0] exp_order [8];
      int n;
      int idle_cyc;
      exp_order = '{8'h44, 8'h44, 8'h44, 8'h49, 8'h44, 8'h44, 8'h44, 8'h49};
      for (int i = 0; i < 8; i++) order[i] = 8'h2D;
      n = 0;
      idle_cyc = 0;
      bus1.dm_req = 1'b1;
      bus1.dm_we = 1'b0;
      bus1.dm_addr = 8'h12;
      bus1.if_req = 1'b1;
      bus1.if_addr = 8'h11;
      for (int c = 0; c < 40 && n < 8; c++) begin
         tick();
         if (!bus1.busy) idle_cyc++;
         if (bus1.dm_gnt) begin order[n] = 8'h44; n++; end
         else if (bus1.if_gnt) begin order[n] = 8'h49; n++; end
      end
      bus1.dm_req = 1'b0;
      bus1.if_req = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (order[i] !== exp_order[i]) begin
            bad++;
            $display("FAIL burst_grant_%0d: got %s want %s", i, order[i], exp_order[i]);
         end
      end
      total++;
      if (idle_cyc !== 0) begin bad++; $display("FAIL burst_no_idle: got %0d idle cycles want 0", idle_cyc); end
      total++;
      if (bus1.busy !== 1'b0) begin bad++; $display("FAIL burst_end_idle: got busy=%b want 0", bus1.busy); end
      $display("test_burst_fairness: order %s%s%s%s%s%s%s%s", order[0], order[1], order[2], order[3],
               order[4], order[5], order[6], order[7]);
   endtask

   task automatic test_reset_mid_access();
      logic [38:0] outs3;
      logic [38:0] outs1;
      int valid_cnt;
      int lat;
      int gnt_cyc;
      int we_cyc;
      logic [7:0] rdata;
      bus3.if_req = 1'b1;
      bus3.if_addr = 8'h40;
      tick();
      tick();
      total++;
      if (bus3.if_gnt !== 1'b1) begin bad++; $display("FAIL rst_mid_pre_gnt: got %b want 1", bus3.if_gnt); end
      rst = 1'b1;
      bus3.if_req = 1'b0;
      tick();
      outs3 = {bus3.if_gnt, bus3.if_valid, bus3.if_rdata, bus3.dm_gnt, bus3.dm_valid, bus3.dm_rdata,
               bus3.mem_en, bus3.mem_we, bus3.mem_addr, bus3.mem_wdata, bus3.busy};
      outs1 = {bus1.if_gnt, bus1.if_valid, bus1.if_rdata, bus1.dm_gnt, bus1.dm_valid, bus1.dm_rdata,
               bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.busy};
      total++;
      if (outs3 !== 39'h0) begin bad++; $display("FAIL rst_mid_outs_lat3: got %h want 0", outs3); end
      total++;
      if (outs1 !== 39'h0) begin bad++; $display("FAIL rst_mid_outs_lat1: got %h want 0", outs1); end
      rst = 1'b0;
      valid_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus3.if_valid || bus3.busy) valid_cnt++;
      end
      total++;
      if (valid_cnt !== 0) begin bad++; $display("FAIL rst_mid_no_pulse: got %0d active cycles want 0", valid_cnt); end
      op3(1'b0, 1'b0, 8'h40, 8'h00, lat, gnt_cyc, we_cyc, rdata);
      total++;
      if ({lat, rdata} !== {32'd4, 8'hF5}) begin
         bad++;
         $display("FAIL rst_mid_new_fetch: got lat=%0d data=%h want 4/f5", lat, rdata);
      end
      $display("test_reset_mid_access: refetch 0x40 lat=%0d data=%h", lat, rdata);
   endtask

   task automatic test_drop_req();
      int gnt_cyc;
      int valid_cnt;
      int extra_en;
      logic [7:0] rdata;
      logic seen_valid;
      gnt_cyc = 0;
      valid_cnt = 0;
      extra_en = 0;
      rdata = 8'h00;
      seen_valid = 1'b0;
      bus3.dm_req = 1'b1;
      bus3.dm_we = 1'b0;
      bus3.dm_addr = 8'h30;
      tick();
      if (bus3.dm_gnt) gnt_cyc++;
      bus3.dm_req = 1'b0;
      bus3.dm_addr = 8'h55;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus3.dm_gnt) gnt_cyc++;
         if (seen_valid && bus3.mem_en) extra_en++;
         if (bus3.dm_valid) begin valid_cnt++; rdata = bus3.dm_rdata; seen_valid = 1'b1; end
      end
      total++;
      if (gnt_cyc !== 3) begin bad++; $display("FAIL drop_gnt_cycles: got %0d want 3", gnt_cyc); end
      total++;
      if (valid_cnt !== 1) begin bad++; $display("FAIL drop_valid_pulses: got %0d want 1", valid_cnt); end
      total++;
      if (rdata !== 8'h85) begin bad++; $display("FAIL drop_rdata: got %h want 85", rdata); end
      total++;
      if (extra_en !== 0) begin bad++; $display("FAIL drop_no_second_access: got %0d want 0", extra_en); end
      total++;
      if (bus3.busy !== 1'b0) begin bad++; $display("FAIL drop_end_idle: got %b want 0", bus3.busy); end
      $display("test_drop_req: gnt=%0d valid=%0d data=%h", gnt_cyc, valid_cnt, rdata);
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      preload = 1'b1;
      bus1.if_req = 1'b0;  bus1.if_addr = 8'h00;
      bus1.dm_req = 1'b0;  bus1.dm_we = 1'b0;  bus1.dm_addr = 8'h00;  bus1.dm_wdata = 8'h00;
      bus3.if_req = 1'b0;  bus3.if_addr = 8'h00;
      bus3.dm_req = 1'b0;  bus3.dm_we = 1'b0;  bus3.dm_addr = 8'h00;  bus3.dm_wdata = 8'h00;

      test_reset();
      test_fetch_lat1();
      test_store_load();
      test_back_to_back();
      test_burst_fairness();
      test_reset_mid_access();
      test_drop_req();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
